// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the core LD/ST path and the
// program/data loader port. It takes one transaction at a time, round-robins
// when both sides request together, issues the access for one cycle, waits the
// fixed read latency and returns a one-cycle ack to the winner.
//
// Ports
//   clock, reset_n                   clock (rising edge), async active-low reset
//   core_req/we/addr/wdata, core_ack core requester handshake
//   ldr_req/we/addr/wdata,  ldr_ack  loader requester handshake
//   rd_data                          last load result, held until the next read
//   busy                             high whenever the arbiter is not idle
//   grant_id                         owner of current/last transaction (0 core, 1 loader)
//   mem_en/we/addr/wdata, mem_rdata  data memory interface
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, pick winner, latch its transaction
// ISSUE  | one-cycle mem_en strobe with the latched transaction
// WAIT   | read only: count down MEM_LAT, capture mem_rdata on last
// DONE   | one-cycle ack to the requester named by grant_id
module dmem_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              grant_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rd_q;
    logic              grant_q;
    logic              win_valid;
    logic              win_id;

    // On a tie the side that did not own the last transaction wins; grant_q
    // resets to the loader so the core takes the first tie.
    always_comb begin
        win_valid = core_req | ldr_req;
        win_id    = 1'b0;
        if (core_req && ldr_req) begin
            win_id = ~grant_q;
        end else if (ldr_req) begin
            win_id = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q   <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rd_q      <= '0;
        end else begin
            // The transaction is frozen here; later input changes are ignored.
            if (state == S_IDLE && win_valid) begin
                grant_q   <= win_id;
                lat_we    <= win_id ? ldr_we    : core_we;
                lat_addr  <= win_id ? ldr_addr  : core_addr;
                lat_wdata <= win_id ? ldr_wdata : core_wdata;
            end
            if (state == S_ISSUE && !lat_we) begin
                wait_cnt <= CNT_W'(MEM_LAT);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
                // Count of 1 marks the cycle MEM_LAT after the strobe.
                if (wait_cnt == CNT_W'(1)) begin
                    rd_q <= mem_rdata;
                end
            end
        end
    end

    // Everything below is decoded from registered state only.
    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = (state == S_ISSUE) & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign core_ack  = (state == S_DONE) & ~grant_q;
    assign ldr_ack   = (state == S_DONE) &  grant_q;
    assign busy      = (state != S_IDLE);
    assign grant_id  = grant_q;
    assign rd_data   = rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Drives two arbiter instances from the same requester inputs: u_a with
// MEM_LAT=3 (main checks) and u_b with MEM_LAT=1. Each instance has its own
// memory model; u_a's read pipe returns junk except in the exact valid cycle.
module tb_dmem_arbiter;

    localparam int LAT = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       ldr_req = 1'b0, ldr_we = 1'b0;
    logic [7:0] ldr_addr = '0, ldr_wdata = '0;

    logic       a_core_ack, a_ldr_ack, a_busy, a_grant_id, a_mem_en, a_mem_we;
    logic [7:0] a_rd_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic       b_core_ack, b_ldr_ack, b_busy, b_grant_id, b_mem_en, b_mem_we;
    logic [7:0] b_rd_data, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(LAT)) u_a (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(a_core_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(a_ldr_ack),
        .rd_data(a_rd_data), .busy(a_busy), .grant_id(a_grant_id),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(1)) u_b (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(b_core_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(b_ldr_ack),
        .rd_data(b_rd_data), .busy(b_busy), .grant_id(b_grant_id),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] pipe_d [LAT];
    logic       pipe_v [LAT];
    logic [7:0] b_rd;

    always @(posedge clock) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        pipe_v[0] <= a_mem_en && !a_mem_we;
        pipe_d[0] <= mem_a[a_mem_addr];
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_rd <= mem_b[b_mem_addr];
    end
    assign a_mem_rdata = (pipe_v[LAT-1] === 1'b1) ? pipe_d[LAT-1] : 8'hEE;
    assign b_mem_rdata = b_rd;

    task automatic pulse_reset();
        reset_n = 1'b0; core_req = 1'b0; ldr_req = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_rd = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (a_core_ack !== 1'b0) begin fails++; $display("FAIL reset_core_ack got %b exp 0", a_core_ack); end
        tests++; if (a_ldr_ack !== 1'b0) begin fails++; $display("FAIL reset_ldr_ack got %b exp 0", a_ldr_ack); end
        tests++; if ({a_mem_en, a_mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem_en_we got %b exp 00", {a_mem_en, a_mem_we}); end
        tests++; if ({a_mem_addr, a_mem_wdata, a_rd_data} !== 24'h0) begin fails++; $display("FAIL reset_data got %h exp 000000", {a_mem_addr, a_mem_wdata, a_rd_data}); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        tests++; if (a_grant_id !== 1'b1) begin fails++; $display("FAIL reset_grant got %b exp 1", a_grant_id); end
        reset_n = 1'b1;
        exp_rd = 8'h00;
    endtask

    task automatic test_core_write();
        core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hA5; core_req = 1'b1;
        @(posedge clock); #1;
        tests++; if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 8'h10, 8'hA5})
            begin fails++; $display("FAIL cw_issue got %b%b %h %h exp 11 10 a5", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata); end
        tests++; if (a_core_ack !== 1'b0) begin fails++; $display("FAIL cw_early_ack got %b exp 0", a_core_ack); end
        @(posedge clock); #1;
        tests++; if ({a_core_ack, a_ldr_ack} !== 2'b10) begin fails++; $display("FAIL cw_ack got %b exp 10", {a_core_ack, a_ldr_ack}); end
        core_req = 1'b0;
        @(posedge clock); #1;
        tests++; if ({a_core_ack, a_busy} !== 2'b00) begin fails++; $display("FAIL cw_after got %b exp 00", {a_core_ack, a_busy}); end
        ref_mem[8'h10] = 8'hA5;
    endtask

    task automatic test_ldr_read_lat1();
        ldr_we = 1'b0; ldr_addr = 8'h10; ldr_req = 1'b1;
        @(posedge clock); #1;
        tests++; if ({b_mem_en, b_mem_we, b_busy} !== 3'b101) begin fails++; $display("FAIL lr1_issue got %b exp 101", {b_mem_en, b_mem_we, b_busy}); end
        @(posedge clock); #1;
        tests++; if ({b_mem_en, b_ldr_ack, b_busy} !== 3'b001) begin fails++; $display("FAIL lr1_wait got %b exp 001", {b_mem_en, b_ldr_ack, b_busy}); end
        @(posedge clock); #1;
        tests++; if ({b_ldr_ack, b_core_ack, b_busy} !== 3'b101) begin fails++; $display("FAIL lr1_ack got %b exp 101", {b_ldr_ack, b_core_ack, b_busy}); end
        tests++; if (b_rd_data !== 8'hA5) begin fails++; $display("FAIL lr1_rd_data got %h exp a5", b_rd_data); end
        ldr_req = 1'b0;
        @(posedge clock); #1;
        tests++; if ({b_busy, b_ldr_ack} !== 2'b00) begin fails++; $display("FAIL lr1_idle got %b exp 00", {b_busy, b_ldr_ack}); end
        @(posedge clock); #1;
        tests++; if ({a_ldr_ack, a_rd_data} !== {1'b1, 8'hA5}) begin fails++; $display("FAIL lr3_ack got %b %h exp 1 a5", a_ldr_ack, a_rd_data); end
        exp_rd = 8'hA5;
        @(posedge clock); #1;
    endtask

    task automatic test_lat3_read();
        int ens = 0, first_en = 0, ack_k = 0, busy_bad = 0;
        core_we = 1'b0; core_addr = 8'h21; core_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (a_mem_en) begin ens++; if (first_en == 0) first_en = k; end
            if (k <= 5 && a_busy !== 1'b1) busy_bad++;
            if (k == 4) begin
                tests++; if (a_rd_data !== exp_rd) begin fails++; $display("FAIL l3_rd_early got %h exp %h", a_rd_data, exp_rd); end
            end
            if (a_core_ack === 1'b1 && ack_k == 0) begin
                ack_k = k;
                tests++; if (a_rd_data !== ref_mem[8'h21]) begin fails++; $display("FAIL l3_rd_data got %h exp %h", a_rd_data, ref_mem[8'h21]); end
                core_req = 1'b0;
            end
        end
        tests++; if (ens != 1 || first_en != 1) begin fails++; $display("FAIL l3_mem_en got %0d pulses first %0d exp 1 at 1", ens, first_en); end
        tests++; if (ack_k != 2 + LAT) begin fails++; $display("FAIL l3_ack_cycle got %0d exp %0d", ack_k, 2 + LAT); end
        tests++; if (busy_bad != 0) begin fails++; $display("FAIL l3_busy got %0d low cycles exp 0", busy_bad); end
        exp_rd = ref_mem[8'h21];
        // a following write must not disturb rd_data
        ack_k = 0;
        core_we = 1'b1; core_addr = 8'h22; core_wdata = 8'h3C; core_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (a_core_ack === 1'b1) begin ack_k = k; break; end
        end
        core_req = 1'b0;
        tests++; if (ack_k != 2) begin fails++; $display("FAIL wr_ack_cycle got %0d exp 2", ack_k); end
        tests++; if (a_rd_data !== exp_rd) begin fails++; $display("FAIL wr_keeps_rd got %h exp %h", a_rd_data, exp_rd); end
        ref_mem[8'h22] = 8'h3C;
        @(posedge clock); #1;
    endtask

    task automatic test_round_robin();
        int n = 0;
        int ack_k [4];
        bit ack_who [4];
        bit ack_g [4];
        pulse_reset();
        core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h11;
        ldr_we  = 1'b1; ldr_addr  = 8'h31; ldr_wdata  = 8'h22;
        core_req = 1'b1; ldr_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            tests++; if (a_core_ack && a_ldr_ack) begin fails++; $display("FAIL rr_overlap got 11 exp not both at cycle %0d", k); end
            if (a_core_ack || a_ldr_ack) begin
                ack_who[n] = a_ldr_ack; ack_k[n] = k; ack_g[n] = a_grant_id;
                n++;
                if (n == 4) begin core_req = 1'b0; ldr_req = 1'b0; break; end
            end
        end
        tests++; if (n != 4) begin fails++; $display("FAIL rr_count got %0d exp 4", n); end
        for (int i = 0; i < n; i++) begin
            tests++; if (ack_who[i] != i[0]) begin fails++; $display("FAIL rr_order got %0d exp %0d at %0d", ack_who[i], i % 2, i); end
            tests++; if (ack_g[i] != i[0]) begin fails++; $display("FAIL rr_grant got %0d exp %0d at %0d", ack_g[i], i % 2, i); end
            tests++; if (ack_k[i] != 2 + 3 * i) begin fails++; $display("FAIL rr_timing got %0d exp %0d at %0d", ack_k[i], 2 + 3 * i, i); end
        end
        ref_mem[8'h30] = 8'h11;
        ref_mem[8'h31] = 8'h22;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_in_wait();
        int got = 0;
        ldr_we = 1'b0; ldr_addr = 8'h21; ldr_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++; if ({a_busy, a_mem_en, a_ldr_ack} !== 3'b100) begin fails++; $display("FAIL rw_in_wait got %b exp 100", {a_busy, a_mem_en, a_ldr_ack}); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({a_busy, a_ldr_ack, a_mem_en} !== 3'b000) begin fails++; $display("FAIL rw_async_ctl got %b exp 000", {a_busy, a_ldr_ack, a_mem_en}); end
        tests++; if ({a_mem_addr, a_rd_data, a_grant_id} !== {16'h0, 1'b1}) begin fails++; $display("FAIL rw_async_data got %h %h %b exp 00 00 1", a_mem_addr, a_rd_data, a_grant_id); end
        @(posedge clock); #1;
        tests++; if ({a_busy, a_ldr_ack} !== 2'b00) begin fails++; $display("FAIL rw_held got %b exp 00", {a_busy, a_ldr_ack}); end
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clock); #1;
            if (a_ldr_ack === 1'b1) begin got = k; break; end
        end
        tests++; if (got != 2 + LAT) begin fails++; $display("FAIL rw_reserve got %0d exp %0d", got, 2 + LAT); end
        tests++; if (a_rd_data !== ref_mem[8'h21]) begin fails++; $display("FAIL rw_rd_data got %h exp %h", a_rd_data, ref_mem[8'h21]); end
        ldr_req = 1'b0;
        exp_rd = ref_mem[8'h21];
        @(posedge clock); #1;
    endtask

    task automatic test_drop_req();
        int bad = 0;
        core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h77; core_req = 1'b1;
        @(posedge clock); #1;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h41; core_wdata = 8'h00;
        #1;
        tests++; if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 8'h40, 8'h77})
            begin fails++; $display("FAIL dr_issue got %b%b %h %h exp 11 40 77", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata); end
        @(posedge clock); #1;
        tests++; if ({a_core_ack, a_ldr_ack} !== 2'b10) begin fails++; $display("FAIL dr_ack got %b exp 10", {a_core_ack, a_ldr_ack}); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (a_busy || a_mem_en || a_core_ack || a_ldr_ack) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL dr_stay_idle got %0d active cycles exp 0", bad); end
        tests++; if (a_rd_data !== exp_rd) begin fails++; $display("FAIL dr_rd_kept got %h exp %h", a_rd_data, exp_rd); end
        ref_mem[8'h40] = 8'h77;
    endtask

    task automatic test_random();
        bit         c_on, l_on, first, who, last_g, exp_we;
        int         r, base, got, issued, nserve;
        logic [7:0] ea, ed;
        pulse_reset();
        last_g = 1'b1;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(1, 3);
            c_on = r[0]; l_on = r[1];
            core_we = 1'($urandom_range(0, 1)); core_addr = 8'h40 + 8'($urandom_range(0, 15)); core_wdata = 8'($urandom);
            ldr_we  = 1'($urandom_range(0, 1)); ldr_addr  = 8'h40 + 8'($urandom_range(0, 15)); ldr_wdata  = 8'($urandom);
            core_req = c_on; ldr_req = l_on;
            first  = (c_on && l_on) ? ~last_g : l_on;
            nserve = (c_on && l_on) ? 2 : 1;
            for (int s = 0; s < nserve; s++) begin
                who    = (s == 0) ? first : ~first;
                exp_we = who ? ldr_we : core_we;
                ea     = who ? ldr_addr : core_addr;
                ed     = who ? ldr_wdata : core_wdata;
                base   = (exp_we ? 2 : 2 + LAT) + s;
                got = 0; issued = 0;
                for (int k = 1; k <= 20; k++) begin
                    @(posedge clock); #1;
                    if (a_mem_en === 1'b1) begin
                        issued++;
                        tests++; if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {exp_we, ea, ed})
                            begin fails++; $display("FAIL rnd_issue got %b %h %h exp %b %h %h it %0d", a_mem_we, a_mem_addr, a_mem_wdata, exp_we, ea, ed, it); end
                    end
                    tests++; if ((who ? a_core_ack : a_ldr_ack) !== 1'b0) begin fails++; $display("FAIL rnd_wrong_ack got 1 exp 0 it %0d", it); end
                    if ((who ? a_ldr_ack : a_core_ack) === 1'b1) begin got = k; break; end
                end
                tests++; if (got != base) begin fails++; $display("FAIL rnd_latency got %0d exp %0d it %0d who %0d", got, base, it, who); end
                tests++; if (issued != 1) begin fails++; $display("FAIL rnd_mem_en got %0d exp 1 it %0d", issued, it); end
                tests++; if (a_grant_id !== who) begin fails++; $display("FAIL rnd_grant got %b exp %b it %0d", a_grant_id, who, it); end
                if (exp_we) ref_mem[ea] = ed;
                else        exp_rd = ref_mem[ea];
                tests++; if (a_rd_data !== exp_rd) begin fails++; $display("FAIL rnd_rd_data got %h exp %h it %0d", a_rd_data, exp_rd, it); end
                last_g = who;
                if (who) ldr_req = 1'b0;
                else     core_req = 1'b0;
            end
            repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i]   = 8'(i * 7 + 3);
            mem_b[i]   = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        exp_rd = 8'h00;
        test_reset();
        test_core_write();
        test_ldr_read_lat1();
        test_lat3_read();
        test_round_robin();
        test_reset_in_wait();
        test_drop_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
